// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_operand_sequencer
// Brief    : Streams a buffered signed operand-pair vector into a MAC, drains
//            its pipeline and captures one dot product per job.
//            Optional MAC_SEQ_SAT_EN clamps the captured result.
// Revision : 1.0 - initial release
// ============================================================================
module mac_operand_sequencer #(
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 8,
    parameter  int ACC_W   = 17,
    parameter  int MAC_LAT = 2,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic [ADDR_W:0]   vec_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sat,
    output logic [ACC_W-1:0]  result,
    output logic [DATA_W-1:0] mac_dataa,
    output logic [DATA_W-1:0] mac_datab,
    output logic              mac_clken,
    output logic              mac_sload,
    input  logic [ACC_W-1:0]  mac_result
);

    localparam int CNT_W = $clog2(MAC_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_W:0]  C_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] C_DRAIN = CNT_W'(MAC_LAT);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [2*DATA_W-1:0] r_buf [DEPTH];
    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W:0]     r_len;
    logic [CNT_W-1:0]    r_drain;
    logic                r_cap;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_sat;
    logic [ACC_W-1:0]    r_result;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_clken;
    logic                r_sload;

    logic                w_len_ok;
    logic                w_last;
    logic [2*DATA_W-1:0] w_first_pair;
    logic [ACC_W-1:0]    w_cap_result;
    logic                w_cap_sat;

    assign w_len_ok = (vec_len != '0) && (vec_len <= C_DEPTH);
    assign w_last   = ({1'b0, r_idx} == (r_len - 1'b1));
    // A write to slot 0 in the launch cycle must reach the first issued pair.
    assign w_first_pair = (wr_en && (wr_addr == '0)) ? {wr_a, wr_b} : r_buf[0];

`ifdef MAC_SEQ_SAT_EN
    logic w_ovf;
    // Top two bits disagree: value is outside the (ACC_W-1)-bit signed range.
    assign w_ovf        = mac_result[ACC_W-1] ^ mac_result[ACC_W-2];
    assign w_cap_result = w_ovf ? {{2{mac_result[ACC_W-1]}}, {(ACC_W-2){~mac_result[ACC_W-1]}}}
                                : mac_result;
    assign w_cap_sat    = w_ovf;
`else
    assign w_cap_result = mac_result;
    assign w_cap_sat    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if ((r_state == S_IDLE) && wr_en) begin
            r_buf[wr_addr] <= {wr_a, wr_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_len    <= '0;
            r_drain  <= '0;
            r_cap    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_sat    <= 1'b0;
            r_result <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_clken  <= 1'b0;
            r_sload  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_cap  <= 1'b0;
            if (r_cap) begin
                r_result <= w_cap_result;
                r_sat    <= w_cap_sat;
                r_done   <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_clken <= 1'b0;
                    r_sload <= 1'b0;
                    r_a     <= '0;
                    r_b     <= '0;
                    if (start) begin
                        if (w_len_ok) begin
                            r_len        <= vec_len;
                            r_idx        <= '0;
                            r_state      <= S_ISSUE;
                            r_busy       <= 1'b1;
                            r_clken      <= 1'b1;
                            r_sload      <= 1'b1;
                            {r_a, r_b}   <= w_first_pair;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_sload <= 1'b0;
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_drain <= C_DRAIN;
                        r_a     <= '0;
                        r_b     <= '0;
                    end else begin
                        r_idx      <= r_idx + 1'b1;
                        {r_a, r_b} <= r_buf[r_idx + 1'b1];
                    end
                end
                S_DRAIN: begin
                    if (r_drain == C_ONE) begin
                        // Sum appears on mac_result now; sample it on the next edge.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_clken <= 1'b0;
                        r_cap   <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_clken <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign sat       = r_sat;
    assign result    = r_result;
    assign mac_dataa = r_a;
    assign mac_datab = r_b;
    assign mac_clken = r_clken;
    assign mac_sload = r_sload;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_operand_sequencer
// Brief    : Self-checking bench with a behavioural 2-stage MAC and a
//            dot-product reference model; honours MAC_SEQ_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_operand_sequencer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_a;
    logic [7:0]  wr_b;
    logic [3:0]  vec_len;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic        sat;
    logic [16:0] result;
    logic [7:0]  mac_dataa;
    logic [7:0]  mac_datab;
    logic        mac_clken;
    logic        mac_sload;
    logic [16:0] mac_result;

    int n_cmp = 0;
    int n_err = 0;
    int mba [8];
    int mbb [8];

    mac_operand_sequencer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
        .vec_len(vec_len), .start(start), .busy(busy), .done(done), .err(err), .sat(sat),
        .result(result), .mac_dataa(mac_dataa), .mac_datab(mac_datab), .mac_clken(mac_clken),
        .mac_sload(mac_sload), .mac_result(mac_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: product stage, delay stage, accumulator (latency 2).
    logic signed [15:0] p1, p2;
    logic               s1, s2;
    logic signed [16:0] m_acc;
    always @(posedge clk) begin
        if (rst) begin
            p1 <= '0; p2 <= '0; s1 <= 1'b0; s2 <= 1'b0; m_acc <= '0;
        end else if (mac_clken) begin
            p1    <= $signed(mac_dataa) * $signed(mac_datab);
            s1    <= mac_sload;
            p2    <= p1;
            s2    <= s1;
            m_acc <= s2 ? {p2[15], p2} : m_acc + {p2[15], p2};
        end
    end
    assign mac_result = m_acc;

    function automatic logic [17:0] exp_dot(input int len);
        int s;
        logic signed [16:0] w;
        s = 0;
        for (int i = 0; i < len; i++) s += mba[i] * mbb[i];
        w = 17'(s);
`ifdef MAC_SEQ_SAT_EN
        if (int'(w) > 32767)  return {1'b1, 17'h0_7FFF};
        if (int'(w) < -32768) return {1'b1, 17'h1_8000};
`endif
        return {1'b0, w};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_pair(input int addr, input int a, input int b);
        wr_en = 1'b1; wr_addr = 3'(addr); wr_a = 8'(a); wr_b = 8'(b);
        tick;
        wr_en = 1'b0;
        mba[addr] = a;
        mbb[addr] = b;
    endtask

    function automatic int rnd_s8();
        logic [7:0] r;
        r = 8'($urandom_range(0, 255));
        return int'($signed(r));
    endfunction

    task automatic clear_model;
        for (int i = 0; i < 8; i++) begin
            mba[i] = 0;
            mbb[i] = 0;
        end
    endtask

    // Launches a job now (so a call during a done cycle chains back-to-back).
    task automatic run_job(input int len, input bit disturb, output int lat, output int n_clk,
                           output int n_sl, output logic [1:0] first);
        vec_len = 4'(len);
        start   = 1'b1;
        tick;
        start = 1'b0;
        lat   = -1;
        n_clk = 0;
        n_sl  = 0;
        first = {mac_clken, mac_sload};
        for (int c = 0; c < 60; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (mac_clken) n_clk++;
            if (mac_sload) n_sl++;
            if (disturb && c == 2) begin
                start = 1'b1; vec_len = 4'd1;
                wr_en = 1'b1; wr_addr = 3'd1; wr_a = 8'h07; wr_b = 8'h07;
            end else if (disturb && c == 3) begin
                start = 1'b0; wr_en = 1'b0;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        int lat, nc, ns;
        logic [1:0] f;
        n_cmp++;
        if ({busy, done, err, sat, result, mac_dataa, mac_datab, mac_clken, mac_sload} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b clken=%b result=%0d, want all zero", busy, mac_clken, result);
        end
        write_pair(0, 100, 100);
        write_pair(1, -50, 90);
        vec_len = 4'd2; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        tick;
        n_cmp++;
        if ({busy, done, err, sat, result, mac_dataa, mac_datab, mac_clken, mac_sload} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_activity: got busy=%b clken=%b data=%h/%h, want all zero", busy, mac_clken, mac_dataa, mac_datab);
        end
        rst = 1'b0;
        clear_model();
        run_job(1, 1'b0, lat, nc, ns, f);
        n_cmp++;
        if ({lat, sat, result} !== {32'd4, 1'b0, 17'd0}) begin
            n_err++;
            $display("FAIL reset_buffer_clear: got lat=%0d result=%0d, want lat=4 result=0", lat, result);
        end
    endtask

    task automatic test_basic;
        int lat, nc, ns;
        logic [1:0] f;
        write_pair(0, -1, -128);
        write_pair(1, 55, 127);
        write_pair(2, -121, -128);
        run_job(3, 1'b0, lat, nc, ns, f);
        n_cmp++;
        if (lat !== 6) begin n_err++; $display("FAIL basic_latency: got %0d want 6", lat); end
        n_cmp++;
        if ({nc, ns, f} !== {32'd5, 32'd1, 2'b11}) begin
            n_err++;
            $display("FAIL basic_handshake: got clken=%0d sload=%0d first=%b want 5/1/11", nc, ns, f);
        end
        n_cmp++;
        if (result !== 17'd22601) begin n_err++; $display("FAIL basic_result: got %0d want 22601", result); end
        n_cmp++;
        if ({sat, result} !== exp_dot(3)) begin n_err++; $display("FAIL basic_model: got %h want %h", {sat, result}, exp_dot(3)); end
    endtask

    task automatic test_back_to_back;
        int lat, nc, ns;
        logic [1:0] f;
        write_pair(0, -128, -128);
        run_job(1, 1'b0, lat, nc, ns, f);
        n_cmp++;
        if ({lat, result} !== {32'd4, 17'd16384}) begin
            n_err++;
            $display("FAIL b2b_first: got lat=%0d result=%0d want 4/16384", lat, result);
        end
        run_job(1, 1'b0, lat, nc, ns, f);
        n_cmp++;
        if ({lat, f, result} !== {32'd4, 2'b11, 17'd16384}) begin
            n_err++;
            $display("FAIL b2b_second: got lat=%0d first=%b result=%0d want 4/11/16384", lat, f, result);
        end
    endtask

    task automatic test_busy_ignore;
        int lat, nc, ns;
        logic [1:0] f;
        write_pair(0, -1, -128);
        write_pair(1, 55, 127);
        write_pair(2, -121, -128);
        run_job(3, 1'b1, lat, nc, ns, f);
        n_cmp++;
        if ({lat, result} !== {32'd6, 17'd22601}) begin
            n_err++;
            $display("FAIL busy_ignore_job: got lat=%0d result=%0d want 6/22601", lat, result);
        end
        tick;
        n_cmp++;
        if ({busy, done, err} !== 3'b000) begin
            n_err++;
            $display("FAIL busy_no_queue: got busy=%b done=%b err=%b want 000", busy, done, err);
        end
        run_job(3, 1'b0, lat, nc, ns, f);
        n_cmp++;
        if (result !== 17'd22601) begin n_err++; $display("FAIL busy_buffer_intact: got %0d want 22601", result); end
        for (int k = 0; k < 2; k++) begin
            vec_len = (k == 0) ? 4'd0 : 4'd9;
            start = 1'b1;
            tick;
            start = 1'b0;
            n_cmp++;
            if ({err, busy, mac_clken} !== 3'b100) begin
                n_err++;
                $display("FAIL err_pulse len=%0d: got err=%b busy=%b clken=%b want 100", vec_len, err, busy, mac_clken);
            end
            tick;
            n_cmp++;
            if ({err, busy} !== 2'b00) begin
                n_err++;
                $display("FAIL err_one_cycle len=%0d: got err=%b busy=%b want 00", vec_len, err, busy);
            end
        end
    endtask

    task automatic test_saturate;
        int lat, nc, ns;
        logic [1:0] f;
        logic [17:0] want;
`ifdef MAC_SEQ_SAT_EN
        want = {1'b1, 17'd32767};
`else
        want = {1'b0, 17'd49152};
`endif
        for (int i = 0; i < 3; i++) write_pair(i, -128, -128);
        run_job(3, 1'b0, lat, nc, ns, f);
        n_cmp++;
        if ({sat, result} !== want) begin
            n_err++;
            $display("FAIL saturate: got sat=%b result=%0d want sat=%b result=%0d", sat, result, want[17], want[16:0]);
        end
        n_cmp++;
        if ({sat, result} !== exp_dot(3)) begin n_err++; $display("FAIL saturate_model: got %h want %h", {sat, result}, exp_dot(3)); end
    endtask

    task automatic test_reset_mid;
        int lat, nc, ns, n_done;
        logic [1:0] f;
        for (int i = 0; i < 8; i++) write_pair(i, rnd_s8(), rnd_s8());
        vec_len = 4'd8; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        n_cmp++;
        if ({mac_clken, busy, done, result} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got clken=%b busy=%b done=%b result=%0d want zeros", mac_clken, busy, done, result);
        end
        rst = 1'b0;
        clear_model();
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) n_done++;
            tick;
        end
        n_cmp++;
        if (n_done !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d done pulses want 0", n_done); end
        write_pair(0, rnd_s8(), rnd_s8());
        write_pair(1, rnd_s8(), rnd_s8());
        run_job(2, 1'b0, lat, nc, ns, f);
        n_cmp++;
        if ({lat, sat, result} !== {32'd5, exp_dot(2)}) begin
            n_err++;
            $display("FAIL abort_recover: got lat=%0d sat=%b result=%0d want lat=5 %h", lat, sat, result, exp_dot(2));
        end
    endtask

    task automatic test_random;
        int lat, nc, ns, len;
        logic [1:0] f;
        for (int j = 0; j < 10; j++) begin
            len = (j == 0) ? 8 : int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) write_pair(i, rnd_s8(), rnd_s8());
            run_job(len, 1'b0, lat, nc, ns, f);
            n_cmp++;
            if ({lat, nc, ns} !== {len + 3, len + 2, 32'd1}) begin
                n_err++;
                $display("FAIL random_timing job=%0d len=%0d: got lat=%0d clken=%0d sload=%0d", j, len, lat, nc, ns);
            end
            n_cmp++;
            if ({sat, result} !== exp_dot(len)) begin
                n_err++;
                $display("FAIL random_result job=%0d len=%0d: got %h want %h", j, len, {sat, result}, exp_dot(len));
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0; vec_len = '0; start = 1'b0;
        clear_model();
        tick;
        tick;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_busy_ignore();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
